// File: rtl/bcd_seq_alu_if.sv
// bcd_seq_alu_if: request/response bundle between a requester and the BCD sequential ALU
interface bcd_seq_alu_if #(
    parameter int DIGIT_NUM = 8
);
    localparam int W = 4 * DIGIT_NUM;
    logic start;
    logic [2:0] operation;
    logic [W-1:0] operand0;
    logic [W-1:0] operand1;
    logic operand0_sign;
    logic operand1_sign;
    logic busy;
    logic done;
    logic [W-1:0] result;
    logic flag_sign;
    logic flag_ov;
    logic flag_err;
    modport master (
        output start, operation, operand0, operand1, operand0_sign, operand1_sign,
        input busy, done, result, flag_sign, flag_ov, flag_err
    );
    modport slave (
        input start, operation, operand0, operand1, operand0_sign, operand1_sign,
        output busy, done, result, flag_sign, flag_ov, flag_err
    );
endinterface

// File: rtl/bcd_seq_alu.sv
// bcd_seq_alu: signed-magnitude packed-BCD add/subtract (one cycle) and shift-and-add multiply
module bcd_seq_alu #(
    parameter int DIGIT_NUM = 8
) (
    input logic clk,
    input logic rst_n,
    bcd_seq_alu_if.slave bus
);
    localparam int W = 4 * DIGIT_NUM;
    localparam int W2 = 2 * W;
    localparam int IW = $clog2(DIGIT_NUM) + 1;
    typedef enum logic [1:0] {IDLE, EXEC_AS, MUL_ADD, MUL_SHIFT} state_t;
    state_t state;
    logic [W-1:0] a, b;
    logic sa, sb;
    logic [2:0] op;
    logic [W2-1:0] acc, mcand, acc_nxt;
    logic [3:0] cnt;
    logic [IW-1:0] idx;
    logic [W:0] sum_as;
    logic [W-1:0] as_res;
    logic eff_sb, same, ge, as_err, as_ov, as_sign;
    function automatic logic bcd_ok(input logic [W-1:0] x);
        bcd_ok = 1'b1;
        for (int i = 0; i < DIGIT_NUM; i++)
            if (x[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
    endfunction
    function automatic logic [W2-1:0] bcd_add(input logic [W2-1:0] x, input logic [W2-1:0] y);
        logic c;
        logic [4:0] t;
        c = 1'b0;
        bcd_add = '0;
        for (int i = 0; i < 2 * DIGIT_NUM; i++) begin
            t = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'd0, c};
            c = t > 5'd9;
            bcd_add[4*i +: 4] = c ? 4'(t - 5'd10) : t[3:0];
        end
    endfunction
    function automatic logic [W-1:0] bcd_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic br;
        logic [4:0] t;
        br = 1'b0;
        bcd_sub = '0;
        for (int i = 0; i < DIGIT_NUM; i++) begin
            t = {1'b0, x[4*i +: 4]} - {1'b0, y[4*i +: 4]} - {4'd0, br};
            br = t[4];
            bcd_sub[4*i +: 4] = br ? 4'(t + 5'd10) : t[3:0];
        end
    endfunction
    always_comb begin
        eff_sb = sb ^ (op == 3'b001);
        same = sa == eff_sb;
        ge = a >= b;
        sum_as = (W + 1)'(bcd_add({{W{1'b0}}, a}, {{W{1'b0}}, b}));
        as_err = op[2] | op[1] | !bcd_ok(a) | !bcd_ok(b);
        as_res = as_err ? '0 : same ? sum_as[W-1:0] : ge ? bcd_sub(a, b) : bcd_sub(b, a);
        as_ov = !as_err & same & sum_as[W];
        as_sign = ((same | ge) ? sa : !sa) & ((|as_res) | as_ov);
        acc_nxt = bcd_add(acc, mcand);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a <= '0;
            b <= '0;
            sa <= 1'b0;
            sb <= 1'b0;
            op <= '0;
            acc <= '0;
            mcand <= '0;
            cnt <= '0;
            idx <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.result <= '0;
            bus.flag_sign <= 1'b0;
            bus.flag_ov <= 1'b0;
            bus.flag_err <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    a <= bus.operand0;
                    b <= bus.operand1;
                    sa <= bus.operand0_sign;
                    sb <= bus.operand1_sign;
                    op <= bus.operation;
                    acc <= '0;
                    mcand <= {{W{1'b0}}, bus.operand0};
                    idx <= '0;
                    cnt <= bus.operand1[3:0];
                    bus.busy <= 1'b1;
                    state <= (bus.operation == 3'b010 && bcd_ok(bus.operand0) && bcd_ok(bus.operand1))
                        ? MUL_ADD : EXEC_AS;
                end
                EXEC_AS: begin
                    bus.result <= as_res;
                    bus.flag_sign <= as_sign;
                    bus.flag_ov <= as_ov;
                    bus.flag_err <= as_err;
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
                MUL_ADD: if (cnt != 4'd0) begin
                    acc <= acc_nxt;
                    cnt <= cnt - 4'd1;
                end else begin
                    state <= MUL_SHIFT;
                end
                MUL_SHIFT: begin
                    mcand <= mcand << 4;
                    idx <= idx + IW'(1);
                    if (idx == IW'(DIGIT_NUM - 1)) begin
                        bus.result <= acc[W-1:0];
                        bus.flag_ov <= |acc[W2-1:W];
                        bus.flag_sign <= (sa ^ sb) & (|acc);
                        bus.flag_err <= 1'b0;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= b[4*(int'(idx) + 1) +: 4];
                        state <= MUL_ADD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_seq_alu.sv
// tb_bcd_seq_alu: randomized and directed checks of bcd_seq_alu against an integer-arithmetic model
module tb_bcd_seq_alu;
    localparam int D = 8;
    localparam int W = 4 * D;
    typedef struct packed {
        logic [7:0] lat;
        logic busy_acc;
        logic done_after;
        logic [W-1:0] res;
        logic sg;
        logic ov;
        logic er;
    } out_t;
    typedef struct packed {
        logic [2:0] op;
        logic sa;
        logic [W-1:0] a;
        logic sb;
        logic [W-1:0] b;
        logic [7:0] lat;
        logic [W-1:0] res;
        logic sg;
        logic ov;
        logic er;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    bcd_seq_alu_if #(.DIGIT_NUM(D)) bus ();
    bcd_seq_alu #(.DIGIT_NUM(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    function automatic longint to_int(input logic [W-1:0] x);
        longint r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(x[4*i +: 4]);
        return r;
    endfunction
    function automatic logic [W-1:0] to_bcd(input longint v);
        logic [W-1:0] x = '0;
        for (int i = 0; i < D; i++) begin
            x[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return x;
    endfunction
    function automatic logic [W-1:0] rand_bcd(input int nd);
        logic [W-1:0] x = '0;
        for (int i = 0; i < nd; i++) x[4*i +: 4] = 4'($urandom_range(0, 9));
        return x;
    endfunction
    function automatic out_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sa, input logic sb);
        out_t m = '0;
        longint lim = 1, va, vb, t, mag;
        bit bad = 0;
        m.busy_acc = 1'b1;
        m.lat = 8'd1;
        for (int i = 0; i < D; i++) begin
            lim = lim * 10;
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1;
        end
        if (bad || op > 3'd2) begin
            m.er = 1'b1;
            return m;
        end
        if (op == 3'd2) begin
            mag = to_int(a) * to_int(b);
            m.sg = (sa ^ sb) && mag != 0;
            m.lat = 8'd0;
            for (int i = 0; i < D; i++) m.lat = m.lat + 8'(b[4*i +: 4]) + 8'd2;
        end else begin
            va = sa ? -to_int(a) : to_int(a);
            vb = (sb ^ (op == 3'd1)) ? -to_int(b) : to_int(b);
            t = va + vb;
            mag = t < 0 ? -t : t;
            m.sg = t < 0;
        end
        m.res = to_bcd(mag % lim);
        m.ov = mag >= lim;
        return m;
    endfunction
    function automatic string fmt(input out_t o);
        return $sformatf("lat=%0d busy=%b done_next=%b res=%h sign=%b ov=%b err=%b",
                         o.lat, o.busy_acc, o.done_after, o.res, o.sg, o.ov, o.er);
    endfunction
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sa, input logic sb, input bit poke, output out_t o);
        bus.operation = op;
        bus.operand0 = a;
        bus.operand1 = b;
        bus.operand0_sign = sa;
        bus.operand1_sign = sb;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        o = '0;
        o.busy_acc = bus.busy;
        for (int n = 1; n <= 250; n++) begin
            if (poke) begin
                bus.start = n[0];
                bus.operation = 3'd0;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                o.lat = 8'(n);
                break;
            end
        end
        bus.start = 1'b0;
        o.res = bus.result;
        o.sg = bus.flag_sign;
        o.ov = bus.flag_ov;
        o.er = bus.flag_err;
        @(posedge clk);
        #1;
        o.done_after = bus.done;
    endtask
    task automatic test_reset();
        logic [W+4:0] outs;
        bus.start = 1'b1;
        bus.operation = 3'd0;
        bus.operand0 = 32'h00000045;
        bus.operand1 = 32'h00000078;
        bus.operand0_sign = 1'b0;
        bus.operand1_sign = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        outs = {bus.busy, bus.done, bus.result, bus.flag_sign, bus.flag_ov, bus.flag_err};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h required 0", outs);
        end
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        outs = {bus.busy, bus.done, bus.result, bus.flag_sign, bus.flag_ov, bus.flag_err};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_release: outputs=%h required 0", outs);
        end
    endtask
    task automatic test_directed();
        vec_t v[15];
        out_t o, e;
        v = '{
            {3'd0, 1'b0, 32'h00000045, 1'b0, 32'h00000078, 8'd1, 32'h00000123, 1'b0, 1'b0, 1'b0},
            {3'd1, 1'b0, 32'h00000012, 1'b0, 32'h00000045, 8'd1, 32'h00000033, 1'b1, 1'b0, 1'b0},
            {3'd0, 1'b1, 32'h00000050, 1'b0, 32'h00000050, 8'd1, 32'h00000000, 1'b0, 1'b0, 1'b0},
            {3'd0, 1'b0, 32'h99999999, 1'b0, 32'h00000001, 8'd1, 32'h00000000, 1'b0, 1'b1, 1'b0},
            {3'd1, 1'b1, 32'h99999999, 1'b0, 32'h00000001, 8'd1, 32'h00000000, 1'b1, 1'b1, 1'b0},
            {3'd2, 1'b1, 32'h00000012, 1'b0, 32'h00000012, 8'd19, 32'h00000144, 1'b1, 1'b0, 1'b0},
            {3'd2, 1'b0, 32'h00010000, 1'b0, 32'h00010000, 8'd17, 32'h00000000, 1'b0, 1'b1, 1'b0},
            {3'd3, 1'b0, 32'h00000045, 1'b0, 32'h00000078, 8'd1, 32'h00000000, 1'b0, 1'b0, 1'b1},
            {3'd0, 1'b0, 32'h0000000A, 1'b0, 32'h00000001, 8'd1, 32'h00000000, 1'b0, 1'b0, 1'b1},
            {3'd2, 1'b0, 32'h00000012, 1'b0, 32'h000000B0, 8'd1, 32'h00000000, 1'b0, 1'b0, 1'b1},
            {3'd2, 1'b0, 32'h00000000, 1'b1, 32'h99999999, 8'd88, 32'h00000000, 1'b0, 1'b0, 1'b0},
            {3'd1, 1'b0, 32'h00000100, 1'b1, 32'h00000005, 8'd1, 32'h00000105, 1'b0, 1'b0, 1'b0},
            {3'd0, 1'b1, 32'h00000030, 1'b0, 32'h00000100, 8'd1, 32'h00000070, 1'b0, 1'b0, 1'b0},
            {3'd2, 1'b1, 32'h99999999, 1'b1, 32'h99999999, 8'd88, 32'h00000001, 1'b0, 1'b1, 1'b0},
            {3'd1, 1'b1, 32'h00000005, 1'b1, 32'h00000005, 8'd1, 32'h00000000, 1'b0, 1'b0, 1'b0}
        };
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, v[i].sa, v[i].sb, 1'b0, o);
            e = '{lat: v[i].lat, busy_acc: 1'b1, done_after: 1'b0, res: v[i].res,
                  sg: v[i].sg, ov: v[i].ov, er: v[i].er};
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL directed_%0d: got %s required %s", i, fmt(o), fmt(e));
            end
        end
    endtask
    task automatic test_random();
        out_t o, e;
        logic [2:0] op;
        logic [W-1:0] a, b;
        logic sa, sb;
        int r;
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            op = r < 9 ? 3'(r % 3) : 3'($urandom_range(3, 7));
            a = rand_bcd(int'($urandom_range(1, D)));
            b = rand_bcd(int'($urandom_range(1, D)));
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) a[4*$urandom_range(0, D - 1) +: 4] = 4'($urandom_range(10, 15));
            e = model(op, a, b, sa, sb);
            run_op(op, a, b, sa, sb, 1'b0, o);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL random_%0d op=%0d a=%b%h b=%b%h: got %s required %s",
                         i, op, sa, a, sb, b, fmt(o), fmt(e));
            end
        end
    endtask
    task automatic test_start_during_mul();
        out_t o, e;
        logic [W-1:0] a, b;
        e = model(3'd2, 32'h00000012, 32'h00000012, 1'b1, 1'b0);
        run_op(3'd2, 32'h00000012, 32'h00000012, 1'b1, 1'b0, 1'b1, o);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL start_during_mul_fixed: got %s required %s", fmt(o), fmt(e));
        end
        a = rand_bcd(4);
        b = rand_bcd(3);
        e = model(3'd2, a, b, 1'b0, 1'b1);
        run_op(3'd2, a, b, 1'b0, 1'b1, 1'b1, o);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL start_during_mul_rand: got %s required %s", fmt(o), fmt(e));
        end
    endtask
    task automatic test_reset_mid_mul();
        logic [W+4:0] outs;
        out_t o, e;
        int dones = 0;
        bus.operation = 3'd2;
        bus.operand0 = 32'h00000099;
        bus.operand1 = 32'h00000099;
        bus.operand0_sign = 1'b1;
        bus.operand1_sign = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        outs = {bus.busy, bus.done, bus.result, bus.flag_sign, bus.flag_ov, bus.flag_err};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_mul_immediate: outputs=%h required 0", outs);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            dones += int'(bus.done) + int'(bus.busy);
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_mul_no_done: done/busy cycles=%0d required 0", dones);
        end
        e = model(3'd0, 32'h00000045, 32'h00000078, 1'b0, 1'b0);
        run_op(3'd0, 32'h00000045, 32'h00000078, 1'b0, 1'b0, 1'b0, o);
        n_checks++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL sum_after_reset: got %s required %s", fmt(o), fmt(e));
        end
    endtask
    task automatic test_back_to_back();
        out_t o, e;
        logic [W-1:0] a, b, prev;
        logic sa, sb;
        bus.operation = 3'd0;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = rand_bcd(D);
            b = rand_bcd(D);
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            bus.operand0 = a;
            bus.operand1 = b;
            bus.operand0_sign = sa;
            bus.operand1_sign = sb;
            e = model(3'd0, a, b, sa, sb);
            @(posedge clk);
            #1;
            o = '0;
            o.busy_acc = bus.busy;
            o.done_after = bus.done;
            if (i > 0) begin
                n_checks++;
                if (bus.result !== prev) begin
                    n_fail++;
                    $display("FAIL b2b_hold_%0d: result=%h required %h", i, bus.result, prev);
                end
            end
            @(posedge clk);
            #1;
            if (i == 4) bus.start = 1'b0;
            o.lat = bus.done ? 8'd1 : 8'd0;
            o.res = bus.result;
            o.sg = bus.flag_sign;
            o.ov = bus.flag_ov;
            o.er = bus.flag_err;
            prev = e.res;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %s required %s", i, fmt(o), fmt(e));
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_stop: busy,done=%b required 00", {bus.busy, bus.done});
        end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_during_mul();
        test_reset_mid_mul();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
